// File: rtl/chan_scan_seq_pkg.sv
// chan_scan_pkg: shared widths and FSM state codes for the channel scan sequencer
// ports: none (package)
package chan_scan_pkg;
  localparam int N_CH = 8;
  localparam int SEL_W = 3;
  localparam int DWELL_W = 8;
  localparam int GAP_W = 4;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_GRANT = 2'd1;
  localparam state_t ST_GAP = 2'd2;
endpackage

// File: rtl/chan_scan_seq_if.sv
// chan_scan_seq_if: request/grant bundle between scan controller and decoder driver
// signals: run, req (controller -> sequencer); sel, sel_en, last, busy (sequencer -> decoder)
interface chan_scan_seq_if;
  import chan_scan_pkg::*;
  logic run;
  logic [N_CH-1:0] req;
  logic [SEL_W-1:0] sel;
  logic sel_en;
  logic last;
  logic busy;
  modport master (output run, req, input sel, sel_en, last, busy);
  modport slave (input run, req, output sel, sel_en, last, busy);
endinterface

// File: rtl/chan_scan_seq_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr with wrap
// ports: req, ptr in; idx (picked channel), valid (any request) out
module rr_pick
  import chan_scan_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             valid
);
  logic [SEL_W-1:0] c;
  // scan farthest-first so the nearest requester to ptr wins
  always_comb begin
    idx = '0;
    c = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      c = ptr + SEL_W'(k);
      if (req[c]) idx = c;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/chan_scan_seq.sv
// chan_scan_seq: round-robin channel scan sequencer with dwell time and break-before-make gap
// ports: clk, rst_n (async active-low), bus (slave: run, req in; sel, sel_en, last, busy out)
module chan_scan_seq
  import chan_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int GAP = 1
) (
  input logic clk,
  input logic rst_n,
  chan_scan_seq_if.slave bus
);
  localparam logic [DWELL_W-1:0] DWELL_LD = DWELL_W'(DWELL - 1);
  localparam logic [DWELL_W-1:0] GAP_LD = DWELL_W'(GAP > 0 ? GAP - 1 : 0);
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, pick_ptr, pick_idx;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic sel_en_q, sel_en_d, last_q, last_d, busy_q, busy_d;
  logic pick_valid, start, grant_end;
  // a grant ending with no gap re-arbitrates from the pointer it is about to store
  assign pick_ptr = (state_q == ST_GRANT) ? sel_q + 1'b1 : ptr_q;
  rr_pick u_pick (.req(bus.req), .ptr(pick_ptr), .idx(pick_idx), .valid(pick_valid));
  assign start = bus.run && pick_valid;
  assign grant_end = cnt_q == '0 || !bus.req[sel_q] || !bus.run;
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    case (state_q)
      ST_GRANT:
        if (!grant_end) cnt_d = cnt_q - 1'b1;
        else begin
          ptr_d = pick_ptr;
          state_d = GAP > 0 ? ST_GAP : start ? ST_GRANT : ST_IDLE;
          cnt_d = GAP > 0 ? GAP_LD : DWELL_LD;
          sel_d = (GAP == 0 && start) ? pick_idx : sel_q;
        end
      ST_GAP:
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          state_d = start ? ST_GRANT : ST_IDLE;
          sel_d = start ? pick_idx : sel_q;
          cnt_d = DWELL_LD;
        end
      default:
        if (start) begin
          state_d = ST_GRANT;
          sel_d = pick_idx;
          cnt_d = DWELL_LD;
        end
    endcase
    sel_en_d = state_d == ST_GRANT;
    busy_d = state_d != ST_IDLE;
    last_d = sel_en_d && cnt_d == '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      sel_en_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      sel_en_q <= sel_en_d;
      last_q <= last_d;
      busy_q <= busy_d;
    end
  assign bus.sel = sel_q;
  assign bus.sel_en = sel_en_q;
  assign bus.last = last_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_chan_scan_seq.sv
// tb_chan_scan_seq: directed and randomized checks of chan_scan_seq (GAP=1 and GAP=0 builds) against a grant-schedule model
module tb_chan_scan_seq;
  import chan_scan_pkg::*;
  localparam int DW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b1;
  logic [7:0] req = 8'hFF;
  logic [5:0] en_v, last_v;
  int errors = 0;
  int checks = 0;
  chan_scan_seq_if ifa();
  chan_scan_seq_if ifb();
  assign ifa.run = run;
  assign ifa.req = req;
  assign ifb.run = run;
  assign ifb.req = req;
  chan_scan_seq #(.DWELL(DW), .GAP(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  chan_scan_seq #(.DWELL(DW), .GAP(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  always #5 clk = ~clk;

  typedef struct {
    bit on;
    int ch;
    int age;
    int gap;
    int ptr;
    int sel;
  } m_t;
  m_t mdl [2];

  function automatic int pick(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  // one cycle of the grant schedule: age counts shown grant cycles, gap counts gap cycles left
  function automatic m_t step(m_t s, int gp, bit rn, logic [7:0] r);
    m_t n = s;
    bit try_g = 1'b0;
    int p;
    if (s.on) begin
      if (s.age < DW && r[s.ch] && rn) n.age = s.age + 1;
      else begin
        n.on = 1'b0;
        n.ptr = (s.ch + 1) % 8;
        n.gap = gp;
        try_g = gp == 0;
      end
    end else if (s.gap > 0) begin
      n.gap = s.gap - 1;
      try_g = n.gap == 0;
    end else try_g = 1'b1;
    p = pick(r, n.ptr);
    if (try_g && rn && p >= 0) begin
      n.on = 1'b1;
      n.ch = p;
      n.sel = p;
      n.age = 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) for (int d = 0; d < 2; d++) mdl[d] <= '{default: 0};
    else for (int d = 0; d < 2; d++) mdl[d] <= step(mdl[d], d == 0 ? 1 : 0, run, req);

  task automatic chk(string nm, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, a, e);
    end
  endtask

  logic [2:0] o_sel [2];
  logic o_en [2], o_last [2], o_busy [2];
  assign o_sel[0] = ifa.sel;
  assign o_sel[1] = ifb.sel;
  assign o_en[0] = ifa.sel_en;
  assign o_en[1] = ifb.sel_en;
  assign o_last[0] = ifa.last;
  assign o_last[1] = ifb.last;
  assign o_busy[0] = ifa.busy;
  assign o_busy[1] = ifb.busy;

  always @(negedge clk)
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("m%0d.sel_en", d), o_en[d], mdl[d].on);
      chk($sformatf("m%0d.busy", d), o_busy[d], mdl[d].on || mdl[d].gap > 0);
      chk($sformatf("m%0d.last", d), o_last[d], mdl[d].on && mdl[d].age == DW);
      chk($sformatf("m%0d.sel", d), o_sel[d], mdl[d].sel);
    end

  task automatic drv(bit rn, bit rr, logic [7:0] r);
    #1;
    rst_n = rn;
    run = rr;
    req = r;
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    chk("rst.sel", ifa.sel, 0);
    chk("rst.sel_en", ifa.sel_en, 0);
    chk("rst.last", ifa.last, 0);
    chk("rst.busy", ifa.busy, 0);
    chk("rst.b_sel_en", ifb.sel_en, 0);
    drv(0, 1, 8'h00);
    cyc(1);
    drv(1, 1, 8'h00);
    cyc(3);
    chk("idle.busy", ifa.busy, 0);
    chk("idle.sel_en", ifa.sel_en, 0);
    drv(1, 1, 8'h04);
    en_v = '0;
    last_v = '0;
    for (int c = 0; c < 6; c++) begin
      cyc(1);
      en_v[c] = ifa.sel_en;
      last_v[c] = ifa.last;
    end
    chk("single.en_seq", en_v, 6'b101111);
    chk("single.last_seq", last_v, 6'b001000);
    chk("single.regrant_sel", ifa.sel, 2);
    drv(1, 1, 8'h00);
    cyc(4);
    drv(0, 1, 8'h00);
    cyc(1);
    drv(1, 1, 8'h81);
    for (int c = 1; c <= 19; c++) begin
      cyc(1);
      chk("rr.sel_en", ifa.sel_en, int'((c - 1) % 5 < 4));
      if ((c - 1) % 5 < 4) chk("rr.sel", ifa.sel, ((c - 1) / 5) % 2 == 1 ? 7 : 0);
    end
    drv(1, 1, 8'h00);
    cyc(4);
    drv(0, 1, 8'h00);
    cyc(1);
    drv(1, 1, 8'h08);
    cyc(1);
    chk("er.sel", ifa.sel, 3);
    chk("er.en1", ifa.sel_en, 1);
    cyc(1);
    chk("er.en2", ifa.sel_en, 1);
    chk("er.last2", ifa.last, 0);
    drv(1, 1, 8'h11);
    cyc(1);
    chk("er.gap_en", ifa.sel_en, 0);
    chk("er.gap_busy", ifa.busy, 1);
    chk("er.gap_last", ifa.last, 0);
    cyc(1);
    chk("er.next_en", ifa.sel_en, 1);
    chk("er.next_sel", ifa.sel, 4);
    drv(1, 1, 8'h00);
    cyc(4);
    drv(1, 1, 8'h01);
    cyc(1);
    chk("rl.sel", ifa.sel, 0);
    chk("rl.en", ifa.sel_en, 1);
    cyc(1);
    drv(1, 0, 8'h01);
    cyc(1);
    chk("rl.gap_en", ifa.sel_en, 0);
    chk("rl.gap_busy", ifa.busy, 1);
    cyc(1);
    chk("rl.idle_en", ifa.sel_en, 0);
    chk("rl.idle_busy", ifa.busy, 0);
    cyc(1);
    chk("rl.hold_en", ifa.sel_en, 0);
    drv(1, 1, 8'h01);
    cyc(1);
    chk("rl.resume_en", ifa.sel_en, 1);
    chk("rl.resume_sel", ifa.sel, 0);
    drv(1, 1, 8'h00);
    cyc(4);
    drv(1, 1, 8'h10);
    cyc(2);
    chk("ar.en", ifa.sel_en, 1);
    chk("ar.sel", ifa.sel, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.async_en", ifa.sel_en, 0);
    chk("ar.async_busy", ifa.busy, 0);
    cyc(1);
    drv(1, 1, 8'h81);
    cyc(1);
    chk("ar.ptr0_sel", ifa.sel, 0);
    chk("ar.ptr0_en", ifa.sel_en, 1);
    drv(1, 1, 8'h00);
    cyc(4);
    drv(0, 1, 8'h00);
    cyc(1);
    drv(1, 1, 8'h06);
    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      chk("g0.sel_en", ifb.sel_en, 1);
      chk("g0.sel", ifb.sel, c <= 4 ? 1 : 2);
      chk("g0.last", ifb.last, int'(c == 4 || c == 8));
    end
    drv(1, 1, 8'h00);
    cyc(4);
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      drv($urandom_range(0, 149) != 0, $urandom_range(0, 7) != 0,
          $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) == 1 ? 8'($urandom) : 8'($urandom & $urandom)) : req);
    end
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/chan_scan_seq.md
# chan_scan_seq

Round-robin channel scan sequencer that sits directly upstream of the 3-to-8 one-hot decoder and drives its `in[2:0]` and `en` inputs. It arbitrates among eight request lines and grants one channel at a time for a programmable dwell time. It inserts a programmable break-before-make gap between grants, so the decoder's one-hot output moves cleanly from channel to channel.

## Interface
- `DWELL`, default 4: grant length in cycles; legal range 1..255 (8-bit counter).
- `GAP`, default 1: idle cycles between consecutive grants; legal range 0..15.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `run`  in  1  global scan enable; no new grants while low.
- `req`  in  8  per-channel request, level-sensitive.
- `sel`  out  3  granted channel index; drives decoder `in`.
- `sel_en`  out  1  grant active; drives decoder `en`.
- `last`  out  1  high on the final cycle of a dwell-expiry grant.
- `busy`  out  1  high in GRANT or GAP state.

## Operation
- All outputs are registered.
- Reset values: `sel`=0, `sel_en`=0, `last`=0, `busy`=0. Internal state: state=IDLE, rr pointer `ptr`=0, counters=0.
- State machine IDLE / GRANT / GAP.
- **Arbitration:** pick the first `i` with `req[i]`=1, searching `ptr, ptr+1, …, 7, 0, …, ptr-1`. The search wraps mod 8. It is combinational and uses `req` sampled in the deciding cycle.
- **IDLE:** `sel_en`=0.
  - If `run` && `|req`: load `sel`=picked index and dwell count = DWELL-1, then go to GRANT.
- **GRANT:** `sel_en`=1, `sel` stable. The dwell counter decrements each cycle. The grant ends after the current cycle on any of:
  - counter==0 (dwell expiry; `last`=1 this cycle),
  - `req[sel]`=0 (early release; `last` stays 0),
  - `run`=0.
- **On grant end:** `ptr` ← `sel`+1, wrapping 7→0.
  - GAP>0: go to GAP, load gap count = GAP-1.
  - GAP==0: arbitrate in the same cycle; either re-enter GRANT with the new `sel` (`sel_en` stays 1) or go to IDLE.
- **GAP:** `sel_en`=0, `sel` holds its last value. The gap counter decrements each cycle. On its last cycle, arbitrate as IDLE does: go to GRANT if `run` && `|req`, else go to IDLE.
- **Simultaneous events:** if expiry and `req[sel]` drop coincide, treat it as expiry (`last`=1). `run` low overrides new arbitration but never truncates GAP.
- **Re-grant of the same channel:** allowed after the gap if it is the only requester. Round-robin resumes from `ptr`.
- **Async reset mid-grant:** `sel_en` and `busy` drop immediately on the `rst_n` fall, and `ptr` returns to 0.
- A `req` change on a non-granted channel never affects the current grant.

## Timing
- Request latency: `req` seen in IDLE in cycle t → `sel_en`=1 from t+1.
- Uninterrupted grant: exactly DWELL cycles of `sel_en`=1. `last` is high on the DWELL-th cycle.
- Early release: `req[sel]` low in cycle t → `sel_en`=0 from t+1 (when GAP>0).
- Back-to-back grants: `sel_en`=0 for exactly GAP cycles. For GAP=0, `sel` changes with no `sel_en` dropout.
- `busy` = (state != IDLE), registered in step with `sel_en`.

## Structure
- Package `chan_scan_pkg`:
  - state enum {IDLE, GRANT, GAP},
  - `N_CH`=8, `SEL_W`=3, `DWELL_W`=8, `GAP_W`=4.
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs `req[7:0]`, `ptr[2:0]`; outputs `idx[2:0]`, `valid`. It is reused by the IDLE and GAP-exit paths.
- The top level holds the FSM, counters, `ptr` and output registers.

## Test plan
- **Reset:** `rst_n`=0 with `req`=8'hFF, `run`=1 → all outputs 0. After release with `req`=0, outputs stay 0 and `busy`=0.
- **Single request:** DWELL=4, GAP=1, `req`=8'b0000_0100 from cycle t.
  - `sel`=2, `sel_en`=1 for t+1..t+4, `last`=1 at t+4.
  - `sel_en`=0 at t+5, re-grant of `sel`=2 at t+6.
- **Round-robin wrap:** `req`=8'b1000_0001 held → grant sequence 0, 7, 0, 7, each 4 cycles, with a 1-cycle gap between grants. `ptr` wraps 7→0.
- **Early release:** grant `sel`=3, `req[3]` drops in the 2nd grant cycle, `req`=8'b0001_0001.
  - `sel_en` falls the next cycle and `last` never asserts.
  - After the gap, `sel`=4 (search starts at `ptr`=4).
- **Interruptions:** `run`=0 mid-grant → `sel_en`=0 next cycle, GAP honoured, then IDLE until `run`=1. A separate case asserts `rst_n`=0 mid-grant → `sel_en` falls asynchronously, and the first grant after reset uses `ptr`=0.
- **GAP=0 build:** `req`=8'b0000_0110 → `sel` 1 then 2 with `sel_en` continuously 1, and `last` high on each grant's 4th cycle.
